// File: rtl/optic_flow_color_sequencer.sv
// Optic-flow colour sequencer: buffers up to two flow words handed over by
// custom instruction, steps the converter through the four pixel-pair groups
// of each word and streams the resulting RGB565 pairs to the frame-buffer
// writer.
//
// Stream handshake: pixelWord/pixelValid are registered; once pixelValid is
// high, both stay unchanged until a cycle with pixelReady=1, and a transfer
// happens exactly on a clock edge where pixelValid && pixelReady.
module optic_flow_color_sequencer #(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        ciStart,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  input  logic [7:0]  ciN,
  output logic        ciDone,
  output logic [31:0] ciResult,
  output logic [31:0] convValueA,
  output logic [1:0]  convIndex,
  input  logic [31:0] convResult,
  output logic [31:0] pixelWord,
  output logic        pixelValid,
  input  logic        pixelReady,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  localparam logic [1:0] OP_SUBMIT = 2'd0;
  localparam logic [1:0] OP_STATUS = 2'd1;
  localparam logic [1:0] OP_CLEAR  = 2'd2;
  localparam logic [1:0] OP_FLUSH  = 2'd3;

  state_e      state_q, state_d;
  logic [31:0] buf_q [0:1];
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] pair_q, pair_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;

  logic        active;
  logic [1:0]  op;
  logic        handshake;
  logic        pop;
  logic        push;
  logic        clear;
  logic        unused_b;

  assign active    = ciStart && (ciN == customInstructionId);
  assign op        = ciValueB[1:0];
  assign unused_b  = ^ciValueB[31:2];
  // In EMIT pixelValid is always high, so ready alone completes a transfer.
  assign handshake = (state_q == S_EMIT) && pixelReady;
  assign pop       = handshake && (idx_q == 2'd3);
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign push      = active && (op == OP_SUBMIT) && ((count_q != 2'd2) || pop);
  assign clear     = active && (op == OP_CLEAR);

  assign convValueA = buf_q[head_q];
  assign convIndex  = idx_q;
  assign pixelWord  = word_q;
  assign pixelValid = valid_q;
  assign busy       = (count_q != 2'd0) || (state_q != S_IDLE);

  // Custom-instruction completion and result, combinational from the request.
  always_comb begin
    ciDone   = 1'b0;
    ciResult = 32'd0;
    if (active) begin
      case (op)
        OP_SUBMIT: ciDone = push;
        OP_STATUS: begin
          ciDone   = 1'b1;
          ciResult = {pair_q, 13'd0, (state_q == S_IDLE), count_q};
        end
        OP_CLEAR:  ciDone = 1'b1;
        OP_FLUSH:  ciDone = (count_q == 2'd0) && (state_q == S_IDLE) && !valid_q;
        default:   ciDone = 1'b0;
      endcase
    end
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    head_d  = pop  ? ~head_q : head_q;
    tail_d  = push ? ~tail_q : tail_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Sequencer next state: load a pair, hold it until accepted, advance group.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    valid_d = valid_q;
    pair_d  = pair_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != 2'd0) state_d = S_LOAD;
      end
      S_LOAD: begin
        word_d  = convResult;
        valid_d = 1'b1;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (pixelReady) begin
          valid_d = 1'b0;
          pair_d  = pair_q + 16'd1;
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = (count_d != 2'd0) ? S_LOAD : S_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Clearing the pair counter overrides a coincident transfer.
    if (clear) pair_d = 16'd0;
  end

  // Control and output registers.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      idx_q   <= 2'd0;
      pair_q  <= 16'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      pair_q  <= pair_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  // Buffer storage; occupancy is tracked by count, so data needs no reset.
  always_ff @(posedge clock) begin
    if (push) buf_q[tail_q] <= ciValueA;
  end

endmodule

// File: tb/tb_optic_flow_color_sequencer.sv
// Directed bench for optic_flow_color_sequencer with a stand-in colour
// converter and a scoreboard of expected pixel pairs.
module tb_optic_flow_color_sequencer;

  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic        ciStart = 1'b0;
  logic [31:0] ciValueA = 32'd0;
  logic [31:0] ciValueB = 32'd0;
  logic [7:0]  ciN = 8'd0;
  logic        ciDone;
  logic [31:0] ciResult;
  logic [31:0] convValueA;
  logic [1:0]  convIndex;
  logic [31:0] convResult;
  logic [31:0] pixelWord;
  logic        pixelValid;
  logic        pixelReady = 1'b0;
  logic        busy;

  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_word = 32'd0;

  optic_flow_color_sequencer #(.customInstructionId(8'd0)) dut (
    .clock      (clock),
    .nReset     (nReset),
    .ciStart    (ciStart),
    .ciValueA   (ciValueA),
    .ciValueB   (ciValueB),
    .ciN        (ciN),
    .ciDone     (ciDone),
    .ciResult   (ciResult),
    .convValueA (convValueA),
    .convIndex  (convIndex),
    .convResult (convResult),
    .pixelWord  (pixelWord),
    .pixelValid (pixelValid),
    .pixelReady (pixelReady),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- converter stand-in ----------------
  function automatic logic [15:0] colour(input logic [3:0] f);
    case (f)
      4'h0:    colour = 16'h0000;
      4'h1:    colour = 16'hF800;
      4'h2:    colour = 16'h07E0;
      4'h4:    colour = 16'h8410;
      4'h8:    colour = 16'h0010;
      default: colour = {f, f, f, f};
    endcase
  endfunction

  function automatic logic [31:0] conv_model(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    b = w[8*k +: 8];
    conv_model = {colour(b[7:4]), colour(b[3:0])};
  endfunction

  assign convResult = conv_model(convValueA, convIndex);

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back(conv_model(w, 2'(k)));
  endtask

  // Stream monitor: sampled mid-cycle, where the coming edge's values are stable.
  always @(negedge clock) begin
    if (!nReset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, pixelValid}, 32'd1);
        check("hold_word", pixelWord, prev_word);
      end
      if (pixelValid && pixelReady) begin
        got_q.push_back(pixelWord);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $error("FAIL sb_extra: observed %08h expected none", pixelWord);
        end else begin
          check("sb_pair", pixelWord, exp_q.pop_front());
        end
      end
      prev_stall = pixelValid && !pixelReady;
      prev_word  = pixelWord;
    end
  end

  // ---------------- driver tasks ----------------
  // mode 0: ready low, 1: ready high, 2: pattern 1,0,0,1, 3: random
  task automatic set_ready(input int mode, input int cyc);
    case (mode)
      0:       pixelReady = 1'b0;
      1:       pixelReady = 1'b1;
      2:       pixelReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: pixelReady = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Called and returns at posedge+1.
  task automatic ci_op(input logic [1:0] op, input logic [31:0] a, input int mode,
                       input int budget, output logic done, output logic [31:0] res,
                       output int waited);
    int c;
    done = 1'b0; res = 32'd0; waited = 0; c = 0;
    ciStart = 1'b1; ciN = 8'd0; ciValueA = a; ciValueB = {30'd0, op};
    while (!done && c < budget) begin
      set_ready(mode, c);
      @(negedge clock); #1;
      if (ciDone) begin
        done = 1'b1;
        res  = ciResult;
      end else begin
        waited++;
      end
      @(posedge clock); #1;
      c++;
    end
    ciStart = 1'b0; ciValueA = 32'd0; ciValueB = 32'd0;
  endtask

  task automatic submit(input logic [31:0] w, input int mode, input int budget,
                        input string tag, output int waited);
    logic done;
    logic [31:0] res;
    ci_op(2'd0, w, mode, budget, done, res, waited);
    check(tag, {31'd0, done}, 32'd1);
    check({tag, "_res"}, res, 32'd0);
    if (done) push_expected(w);
  endtask

  task automatic status(input logic [31:0] exp, input string tag);
    logic done;
    logic [31:0] res;
    int w;
    ci_op(2'd1, 32'd0, 0, 4, done, res, w);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check(tag, res, exp);
  endtask

  task automatic wait_idle(input int mode, input int budget, input string tag);
    logic ok;
    int c;
    ok = 1'b0; c = 0;
    while (!ok && c < budget) begin
      set_ready(mode, c);
      @(negedge clock); #1;
      if (!busy && !pixelValid) ok = 1'b1;
      @(posedge clock); #1;
      c++;
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    logic ok;
    int c;
    ok = 1'b0; c = 0;
    pixelReady = 1'b0;
    while (!ok && c < budget) begin
      @(negedge clock); #1;
      if (pixelValid) ok = 1'b1;
      @(posedge clock); #1;
      c++;
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic done;
    logic [31:0] res;
    int w;

    // Reset state
    #2;
    check("rst_valid", {31'd0, pixelValid}, 32'd0);
    check("rst_word", pixelWord, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, ciDone}, 32'd0);
    check("rst_result", ciResult, 32'd0);
    @(posedge clock); @(posedge clock); #1;
    nReset = 1'b1;
    @(posedge clock); #1;
    status(32'h0000_0004, "status_reset");

    // Single word, ready high: latency, pair contents, pair count
    got_q.delete();
    submit(32'h0000_0084, 1, 2, "submit_84", w);
    check("submit_84_nostall", 32'(w), 32'd0);
    check("lat0_valid", {31'd0, pixelValid}, 32'd0);
    @(posedge clock); #1;
    check("lat1_valid", {31'd0, pixelValid}, 32'd0);
    @(posedge clock); #1;
    check("lat2_valid", {31'd0, pixelValid}, 32'd1);
    check("first_pair", pixelWord, 32'h0010_8410);
    wait_idle(1, 20, "idle_84");
    check("pairs_84", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      check("pair84_0", got_q[0], 32'h0010_8410);
      check("pair84_1", got_q[1], 32'h0000_0000);
      check("pair84_2", got_q[2], 32'h0000_0000);
      check("pair84_3", got_q[3], 32'h0000_0000);
    end
    status(32'h0004_0004, "status_after_84");

    // CLEAR, then fill the buffer with the stream stalled
    ci_op(2'd2, 32'd0, 0, 4, done, res, w);
    check("clear_done", {31'd0, done}, 32'd1);
    check("clear_res", res, 32'd0);
    status(32'h0000_0004, "status_cleared");
    got_q.delete();
    submit(32'h1111_1111, 0, 2, "submit_11", w);
    check("submit_11_nostall", 32'(w), 32'd0);
    submit(32'h2222_2222, 0, 2, "submit_22", w);
    check("submit_22_nostall", 32'(w), 32'd0);
    status(32'h0000_0002, "status_full");

    // Third word stalls until the first word's last pair leaves
    submit(32'h3333_3333, 2, 60, "submit_33", w);
    check("submit_33_stalled", {31'd0, (w > 0)}, 32'd1);
    check("submit_33_at_pop", 32'(got_q.size()), 32'd4);
    wait_idle(2, 100, "idle_33");
    check("pairs_three_words", 32'(got_q.size()), 32'd12);
    status(32'h000C_0004, "status_twelve");

    // FLUSH with two words queued
    got_q.delete();
    submit(32'hA5A5_5A5A, 0, 2, "submit_a5", w);
    submit(32'h0123_4567, 0, 2, "submit_01", w);
    ci_op(2'd3, 32'd0, 3, 300, done, res, w);
    check("flush_done", {31'd0, done}, 32'd1);
    check("flush_res", res, 32'd0);
    check("flush_stalled", {31'd0, (w >= 16)}, 32'd1);
    check("flush_pairs", 32'(got_q.size()), 32'd8);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_valid", {31'd0, pixelValid}, 32'd0);

    // Pair counter wrap
    pixelReady = 1'b0;
    force dut.pair_q = 16'hFFFF;
    @(posedge clock); #1;
    release dut.pair_q;
    status(32'hFFFF_0004, "status_ffff");
    submit(32'hF0F0_F0F0, 1, 2, "submit_f0", w);
    wait_idle(1, 20, "idle_f0");
    status(32'h0003_0004, "status_wrapped");

    // CLEAR coinciding with a handshake
    submit(32'h0F0F_0F0F, 0, 2, "submit_0f", w);
    wait_valid(10, "valid_0f");
    ci_op(2'd2, 32'd0, 1, 4, done, res, w);
    check("clear_hs_done", {31'd0, done}, 32'd1);
    pixelReady = 1'b0;
    status(32'h0000_0001, "status_clear_wins");
    wait_idle(1, 20, "idle_0f");
    status(32'h0003_0004, "status_after_0f");

    // Reset while emitting with two words queued
    submit(32'h5555_AAAA, 0, 2, "submit_55", w);
    submit(32'h1234_8421, 0, 2, "submit_12", w);
    wait_valid(10, "valid_55");
    nReset = 1'b0;
    #1;
    check("midrst_valid", {31'd0, pixelValid}, 32'd0);
    check("midrst_word", pixelWord, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    @(posedge clock); #1;
    nReset = 1'b1;
    @(posedge clock); #1;
    status(32'h0000_0004, "status_after_rst");

    // Normal operation resumes after reset
    got_q.delete();
    submit(32'hDEAD_BEEF, 3, 2, "submit_de", w);
    wait_idle(3, 100, "idle_de");
    check("pairs_de", 32'(got_q.size()), 32'd4);
    status(32'h0004_0004, "status_de");

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/optic_flow_color_sequencer.md
Name: optic_flow_color_sequencer

Overview:
- Custom-instruction-fed controller that drives the optic-flow colour converter datapath.
- Accepts 32-bit flow words from the CPU (8 pixels x 4 flow bits {up,down,left,right}) into a 2-entry buffer.
- Steps the converter through group indices 0..3 per word and emits four 32-bit RGB565 pixel-pair words on a valid/ready stream toward the frame-buffer writer.
- Frees the CPU from issuing four conversion instructions per word.

Parameters:
- customInstructionId, 8'd0, ciN value this block responds to.

Ports:
- clock  in  1  system clock
- nReset  in  1  asynchronous active-low reset
- ciStart  in  1  custom-instruction start
- ciValueA  in  32  operand A (flow word for SUBMIT)
- ciValueB  in  32  operand B; [1:0] = opcode
- ciN  in  8  custom-instruction id
- ciDone  out  1  instruction complete
- ciResult  out  32  instruction result, 0 when not done
- convValueA  out  32  flow word presented to converter
- convIndex  out  2  group index presented to converter
- convResult  in  32  combinational RGB565 pair from converter
- pixelWord  out  32  registered RGB565 pair
- pixelValid  out  1  pixelWord valid
- pixelReady  in  1  downstream accepts
- busy  out  1  buffer non-empty or FSM not IDLE

Behaviour:
- Reset (async, nReset=0): FSM=IDLE, buffer empty, idx=0, pairCount=0, pixelWord=0, pixelValid=0, ciDone=0, ciResult=0. Reset mid-operation discards buffered words and any pending pair.
- Active = ciStart && (ciN==customInstructionId). ciDone and ciResult are combinational from active plus state. ciResult=0 whenever ciDone=0.
- Opcodes (ciValueB[1:0]):
  - 0 SUBMIT: if buffer count<2, or count==2 with a pop this cycle, write ciValueA; ciDone=1 same cycle; result=0. Otherwise ciDone=0 (CPU stalls holding ciStart) until space.
  - 1 STATUS: ciDone=1 same cycle; result={pairCount[15:0], 13'd0, state==IDLE, count[1:0]}.
  - 2 CLEAR: ciDone=1 same cycle; pairCount<=0; result=0. CLEAR wins over a same-cycle increment.
  - 3 FLUSH: ciDone=1 only when buffer empty and FSM=IDLE and pixelValid=0; result=0; else stall.
- Buffer: 2-entry FIFO with head/tail pointers and count 0..2. Push and pop in the same cycle leave count unchanged.
- convValueA = head entry; convIndex = idx (valid in all states; only sampled in LOAD).
- FSM:
  - IDLE: if count>0, go to LOAD.
  - LOAD: pixelWord<=convResult; pixelValid<=1; go to EMIT.
  - EMIT: hold pixelWord/pixelValid stable until pixelReady. On handshake: pixelValid<=0, pairCount++ (16-bit, wraps 0xFFFF->0).
    - If idx==3: pop head, idx<=0, then go to LOAD if the buffer still holds a word after the pop, else IDLE.
    - Otherwise: idx++, go to LOAD.
- Throughput: one pair per 2 cycles with pixelReady=1. Latency from SUBMIT-accept cycle to first pixelValid = 2 cycles (IDLE, LOAD).
- pixelValid never drops without a handshake. pixelWord is never changed while pixelValid=1.
- Pairs for index k carry pixels 2k (bits [15:0]) and 2k+1 (bits [31:16]).

Test Plan:
- Reset, then SUBMIT 0x00000084 with pixelReady=1 -> ciDone same cycle; pixelWord 0x00108410, then 0x00000000 three times; pairCount=4; STATUS returns 0x00040004.
- SUBMIT 0x11111111 and 0x22222222 back-to-back with pixelReady=0 -> both accepted, count=2. A third SUBMIT stalls (ciDone=0) until the first word's index-3 handshake, then ciDone=1 in the pop cycle.
- pixelReady toggled 1,0,0,1 during EMIT -> pixelWord/pixelValid stable across stalls; exactly 4 handshakes per word; no duplicates or drops.
- FLUSH issued with 2 words queued -> ciDone=0 until 8 handshakes complete and FSM returns to IDLE; then ciDone=1 and busy=0.
- Drive pairCount to 0xFFFF, one more handshake -> 0x0000. CLEAR in the same cycle as a handshake -> pairCount=0.
- nReset asserted in EMIT with 2 words queued -> pixelValid=0 immediately, count=0, STATUS after release = 0x00000004.
